// File: rtl/uart_frame_codec.sv
// Delimited frame codec between host logic and byte-level UART PHYs.
// TX wraps a latched payload in delimiter runs; RX strips the runs and reports length or abort.
module uart_frame_codec #(
  parameter int         MAX_LEN        = 137,
  parameter int         LEN_W          = $clog2(MAX_LEN + 1),
  parameter logic [7:0] DELIM          = 8'h26,
  parameter int         DELIM_CNT      = 2,
  parameter int         RX_TIMEOUT_CLK = 1_000_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [MAX_LEN*8-1:0] tx_string,
  input  logic [LEN_W-1:0]     tx_length,
  input  logic                 tx_req,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [7:0]           byte_tx_data,
  output logic                 byte_tx_req,
  input  logic                 byte_tx_done,
  input  logic [7:0]           byte_rx_data,
  input  logic                 byte_rx_vld,
  output logic [MAX_LEN*8-1:0] rx_string,
  output logic [LEN_W-1:0]     rx_length,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic                 rx_err
);
  localparam int                CW        = (LEN_W > 3) ? LEN_W : 3;
  localparam int                TO_W      = $clog2(RX_TIMEOUT_CLK + 1);
  localparam logic [LEN_W-1:0]  MAX_L     = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]    MAX_X     = (LEN_W + 1)'(MAX_LEN);
  localparam logic [CW-1:0]     TX_EDGE   = CW'(DELIM_CNT - 1);
  localparam logic [2:0]        RX_EDGE   = 3'(DELIM_CNT - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RX_TIMEOUT_CLK - 1);

  // ---------------- TX ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_HEAD, TX_BODY, TX_TAIL, TX_FIN} tx_state_t;
  tx_state_t            tx_state, tx_state_nx;
  logic [MAX_LEN*8-1:0] tx_buf;
  logic [LEN_W-1:0]     tx_len;
  logic [CW-1:0]        tx_cnt, tx_cnt_nx, tx_len_m1;
  logic                 tx_issue_nx;
  logic [7:0]           tx_data_nx;

  assign tx_len_m1 = CW'(tx_len) - 1'b1;
  assign tx_busy   = (tx_state == TX_HEAD) || (tx_state == TX_BODY) || (tx_state == TX_TAIL);
  assign tx_done   = (tx_state == TX_FIN);

  // Each byte_tx_done advances the frame by one byte and requests the next one a cycle later.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_issue_nx = 1'b0;
    tx_data_nx  = DELIM;
    case (tx_state)
      TX_IDLE: if (tx_req) begin
        tx_state_nx = TX_HEAD;
        tx_cnt_nx   = '0;
        tx_issue_nx = 1'b1;
      end
      TX_HEAD: if (byte_tx_done) begin
        tx_issue_nx = 1'b1;
        tx_cnt_nx   = tx_cnt + 1'b1;
        if (tx_cnt == TX_EDGE) begin
          tx_cnt_nx = '0;
          if (tx_len == '0) begin
            tx_state_nx = TX_TAIL;
          end else begin
            tx_state_nx = TX_BODY;
            tx_data_nx  = tx_buf[7:0];
          end
        end
      end
      TX_BODY: if (byte_tx_done) begin
        tx_issue_nx = 1'b1;
        if (tx_cnt == tx_len_m1) begin
          tx_state_nx = TX_TAIL;
          tx_cnt_nx   = '0;
        end else begin
          tx_cnt_nx  = tx_cnt + 1'b1;
          tx_data_nx = tx_buf[{tx_cnt_nx, 3'b000} +: 8];
        end
      end
      TX_TAIL: if (byte_tx_done) begin
        if (tx_cnt == TX_EDGE) begin
          tx_state_nx = TX_FIN;
        end else begin
          tx_issue_nx = 1'b1;
          tx_cnt_nx   = tx_cnt + 1'b1;
        end
      end
      TX_FIN:  tx_state_nx = TX_IDLE;
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_len       <= '0;
      tx_buf       <= '0;
      byte_tx_req  <= 1'b0;
      byte_tx_data <= '0;
    end else begin
      tx_state    <= tx_state_nx;
      tx_cnt      <= tx_cnt_nx;
      byte_tx_req <= tx_issue_nx;
      if (tx_issue_nx) byte_tx_data <= tx_data_nx;
      if (tx_state == TX_IDLE && tx_req) begin
        tx_buf <= tx_string;
        tx_len <= (tx_length > MAX_L) ? MAX_L : tx_length;
      end
    end
  end

  // ---------------- RX ----------------
  typedef enum logic {RX_HUNT, RX_BODY} rx_state_t;
  rx_state_t            rx_state, rx_state_nx;
  logic [2:0]           rx_hunt, rx_pend;
  logic [LEN_W-1:0]     rx_wp;
  logic [LEN_W:0]       rx_need;
  logic [TO_W-1:0]      rx_idle;
  logic [MAX_LEN*8-1:0] rx_work;
  logic                 is_delim, rx_start, rx_close, rx_abort, rx_store;

  assign is_delim = (byte_rx_data == DELIM);
  assign rx_need  = {1'b0, rx_wp} + (LEN_W + 1)'(rx_pend) + 1'b1;
  assign rx_busy  = (rx_state == RX_BODY);

  always_comb begin
    rx_state_nx = rx_state;
    rx_start    = 1'b0;
    rx_close    = 1'b0;
    rx_abort    = 1'b0;
    rx_store    = 1'b0;
    case (rx_state)
      RX_HUNT: if (byte_rx_vld && is_delim && rx_hunt == RX_EDGE) begin
        rx_state_nx = RX_BODY;
        rx_start    = 1'b1;
      end
      RX_BODY: begin
        if (byte_rx_vld) begin
          if (is_delim) begin
            if (rx_pend == RX_EDGE) begin
              rx_close    = 1'b1;
              rx_state_nx = RX_HUNT;
            end
          end else if (rx_need > MAX_X) begin
            rx_abort    = 1'b1;
            rx_state_nx = RX_HUNT;
          end else begin
            rx_store = 1'b1;
          end
        end else if (rx_idle == TO_LAST) begin
          rx_abort    = 1'b1;
          rx_state_nx = RX_HUNT;
        end
      end
      default: rx_state_nx = RX_HUNT;
    endcase
  end

  // Payload collects in a working buffer so an aborted frame leaves rx_string at its last good value.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state  <= RX_HUNT;
      rx_hunt   <= '0;
      rx_pend   <= '0;
      rx_wp     <= '0;
      rx_idle   <= '0;
      rx_work   <= '0;
      rx_string <= '0;
      rx_length <= '0;
      rx_done   <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      rx_done  <= rx_close;
      rx_err   <= rx_abort;
      if (rx_state == RX_HUNT) begin
        if (byte_rx_vld) rx_hunt <= (is_delim && !rx_start) ? rx_hunt + 1'b1 : 3'd0;
        rx_pend <= '0;
        rx_wp   <= '0;
        rx_idle <= '0;
      end else begin
        rx_idle <= byte_rx_vld ? '0 : rx_idle + 1'b1;
        if (byte_rx_vld && is_delim) rx_pend <= rx_pend + 1'b1;
        if (rx_store) begin
          for (int j = 0; j < DELIM_CNT; j++) begin
            if (3'(j) < rx_pend) rx_work[{rx_wp + LEN_W'(j), 3'b000} +: 8] <= DELIM;
          end
          rx_work[{rx_wp + LEN_W'(rx_pend), 3'b000} +: 8] <= byte_rx_data;
          rx_wp   <= rx_wp + LEN_W'(rx_pend) + 1'b1;
          rx_pend <= '0;
        end
        if (rx_close) begin
          rx_string <= rx_work;
          rx_length <= rx_wp;
        end
      end
    end
  end
endmodule
